// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and mode constants for the mux_scan selector.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_if.sv
// mux_scan_if: request/response bundle of the mux_scan selector.
// master = producer/consumer side, slave = mux_scan itself.
// With MUX_SCAN_PARITY_EN defined the bundle carries out_par as well.
interface mux_scan_if #(
  parameter int N_CH = 32,
  parameter int W    = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] data;
  logic              mode;
  logic              req;
  logic [SEL_W-1:0]  select;
  logic              start;
  logic [W-1:0]      out;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef MUX_SCAN_PARITY_EN
  logic              out_par;
`endif

  modport master (
    output data, mode, req, select, start, out_ready,
`ifdef MUX_SCAN_PARITY_EN
    input  out_par,
`endif
    input  out, out_ch, out_valid, busy, done
  );

  modport slave (
    input  data, mode, req, select, start, out_ready,
`ifdef MUX_SCAN_PARITY_EN
    output out_par,
`endif
    output out, out_ch, out_valid, busy, done
  );

endinterface

// File: rtl/mux_scan_mux_n.sv
// mux_n: combinational N_CH:1 selector of W-bit words built as a recursive
// even/odd split tree (sel[0] picks the half, sel[SEL_W-1:1] indexes within it).
// Any select at or beyond N_CH yields zero.
module mux_n #(
  parameter int N_CH  = 32,
  parameter int W     = 1,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH*W-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      dout
);
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_CH);

  logic [W-1:0] tree;

  generate
    if (N_CH == 1) begin : g_leaf
      assign tree = din;
    end else if (N_CH == 2) begin : g_pair
      assign tree = sel[0] ? din[W +: W] : din[0 +: W];
    end else begin : g_split
      localparam int N_E   = (N_CH + 1) / 2;
      localparam int N_O   = N_CH / 2;
      localparam int SEL_E = $clog2(N_E);
      localparam int SEL_O = (N_O > 1) ? $clog2(N_O) : 1;

      logic [N_E*W-1:0] din_e;
      logic [N_O*W-1:0] din_o;
      logic [SEL_E-1:0] sel_e;
      logic [SEL_O-1:0] sel_o;
      logic [W-1:0]     word_e;
      logic [W-1:0]     word_o;

      // Regroup channels into even and odd halves
      always_comb begin
        din_e = '0;
        din_o = '0;
        for (int j = 0; j < N_E; j++) din_e[j*W +: W] = din[(2*j)*W +: W];
        for (int j = 0; j < N_O; j++) din_o[j*W +: W] = din[(2*j+1)*W +: W];
      end

      assign sel_e = sel[SEL_E:1];
      assign sel_o = sel_e[SEL_O-1:0];

      mux_n #(.N_CH(N_E), .W(W)) u_even (.din(din_e), .sel(sel_e), .dout(word_e));
      mux_n #(.N_CH(N_O), .W(W)) u_odd  (.din(din_o), .sel(sel_o), .dout(word_o));

      assign tree = sel[0] ? word_o : word_e;
    end
  endgenerate

  assign dout = ({1'b0, sel} < N_LIM) ? tree : '0;

endmodule

// File: rtl/mux_scan.sv
// mux_scan: N_CH-channel, W-bit registered selector with valid/ready output.
// Direct mode samples one channel per req; scan mode sweeps 0..N_CH-1 and
// pulses done once the last sample has been taken by the consumer.
// Optional: define MUX_SCAN_PARITY_EN to add out_par (^ of the captured word).
//
//   state | meaning
//   IDLE  | waiting; direct captures served here, start launches a sweep
//   SCAN  | capturing channel cnt on every free output slot
//   DRAIN | last channel captured, waiting for it to be accepted
//   DONE  | one-cycle done pulse, then back to IDLE
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int N_CH = 32,
  parameter int W    = 1
) (
  input  logic      clk,
  input  logic      rst,
  mux_scan_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] mux_sel;
  logic [W-1:0]     mux_word;
  logic             cap_en;
  logic             slot_free;

  logic [W-1:0]     out_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;
`ifdef MUX_SCAN_PARITY_EN
  logic             par_q;
`endif

  assign slot_free = !valid_q || bus.out_ready;

  // Next state, counter and capture decision; selector source follows the registered state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    mux_sel   = bus.select;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.mode == MODE_SCAN) begin
          if (bus.start) state_nxt = SCAN;
        end else if (bus.req && slot_free) begin
          cap_en = 1'b1;
        end
      end
      SCAN: begin
        mux_sel = cnt;
        if (slot_free) begin
          cap_en  = 1'b1;
          cnt_nxt = cnt + CH_ONE;
          if (cnt == LAST_CH) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (valid_q && bus.out_ready) state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mux_n #(.N_CH(N_CH), .W(W)) u_mux (.din(bus.data), .sel(mux_sel), .dout(mux_word));

  // State, counter and output slot registers; a capture overrides a plain accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      out_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cap_en) begin
        out_q   <= mux_word;
        ch_q    <= mux_sel;
        valid_q <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        par_q   <= ^mux_word;
`endif
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
`ifdef MUX_SCAN_PARITY_EN
  assign bus.out_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: scoreboard bench for mux_scan, two instances:
// A = 12 channels x 8 bits (scan, backpressure, out-of-range, parity),
// B = 32 channels x 1 bit (direct sampling of a fixed and random patterns).
module tb_mux_scan;
  import mux_scan_pkg::*;

  localparam int NA = 12;
  localparam int WA = 8;
  localparam int NB = 32;
  localparam int WB = 1;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  mux_scan_if #(.N_CH(NA), .W(WA)) bus_a ();
  mux_scan_if #(.N_CH(NB), .W(WB)) bus_b ();

  mux_scan #(.N_CH(NA), .W(WA)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  mux_scan #(.N_CH(NB), .W(WB)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  typedef struct {
    logic [7:0] word;
    int         ch;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_a = 0;
  logic [7:0]  dat_a [NA];
  logic [NB-1:0] dat_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual %0d", name, info);
  endtask

  // Reference: the selected channel word, zero past the last channel
  function automatic logic [7:0] ref_a(input int s);
    return (s < NA) ? dat_a[s] : 8'h00;
  endfunction

  task automatic load_a();
    for (int k = 0; k < NA; k++) bus_a.data[k*WA +: WA] = dat_a[k];
  endtask

  // Monitor A: every accepted sample must be the next expected one
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_a && bus_a.out_valid && bus_a.out_ready) begin
        if (q_a.size() == 0) begin
          fail_now("extra_sample_a_ch", int'(bus_a.out_ch));
        end else begin
          e = q_a.pop_front();
          check("out_a", 32'(bus_a.out), 32'(e.word));
          check("out_ch_a", 32'(bus_a.out_ch), e.ch);
`ifdef MUX_SCAN_PARITY_EN
          check("out_par_a", 32'(bus_a.out_par), 32'(^e.word));
`endif
          acc_a++;
        end
      end
    end
  end

  // Monitor B
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_b && bus_b.out_valid && bus_b.out_ready) begin
        if (q_b.size() == 0) begin
          fail_now("extra_sample_b_ch", int'(bus_b.out_ch));
        end else begin
          e = q_b.pop_front();
          check("out_b", 32'(bus_b.out), 32'(e.word[0]));
          check("out_ch_b", 32'(bus_b.out_ch), e.ch);
`ifdef MUX_SCAN_PARITY_EN
          check("out_par_b", 32'(bus_b.out_par), 32'(e.word[0]));
`endif
        end
      end
    end
  end

  task automatic direct_a(input int s);
    exp_t e;
    logic fired;
    int   tries;
    tries  = 0;
    e.word = ref_a(s);
    e.ch   = s;
    q_a.push_back(e);
    bus_a.mode   = MODE_DIRECT;
    bus_a.start  = 1'($urandom_range(0, 1));
    bus_a.select = 4'(s);
    bus_a.req    = 1'b1;
    do begin
      bus_a.out_ready = (tries > 3) ? 1'b1 : 1'($urandom_range(0, 1));
      fired = !bus_a.out_valid || bus_a.out_ready;
      tries++;
      @(negedge clk);
    end while (!fired);
    bus_a.req   = 1'b0;
    bus_a.start = 1'b0;
    check("direct_valid_a", 32'(bus_a.out_valid), 1);
    check("direct_busy_a", 32'(bus_a.busy), 0);
  endtask

  task automatic direct_b(input int s);
    exp_t e;
    logic fired;
    int   tries;
    tries  = 0;
    e.word = {7'd0, dat_b[s]};
    e.ch   = s;
    q_b.push_back(e);
    bus_b.mode   = MODE_DIRECT;
    bus_b.select = 5'(s);
    bus_b.req    = 1'b1;
    do begin
      bus_b.out_ready = (tries > 3) ? 1'b1 : 1'($urandom_range(0, 1));
      fired = !bus_b.out_valid || bus_b.out_ready;
      tries++;
      @(negedge clk);
    end while (!fired);
    bus_b.req = 1'b0;
    check("direct_valid_b", 32'(bus_b.out_valid), 1);
  endtask

  task automatic drain_a();
    bus_a.req       = 1'b0;
    bus_a.start     = 1'b0;
    bus_a.mode      = MODE_DIRECT;
    bus_a.out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // pol 0: ready tied high, 1: random ready, 2: three stall cycles on channel 6
  task automatic scan_a(input int pol, input bit rnd);
    exp_t e;
    int   cyc;
    int   stall;
    logic got_done;
    drain_a();
    for (int k = 0; k < NA; k++) dat_a[k] = rnd ? 8'($urandom) : 8'(8'h10 + k);
    load_a();
    for (int k = 0; k < NA; k++) begin
      e.word = dat_a[k];
      e.ch   = k;
      q_a.push_back(e);
    end
    acc_a = 0;
    bus_a.mode      = MODE_SCAN;
    bus_a.start     = 1'b1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    cyc      = 1;
    stall    = 0;
    got_done = 1'b0;
    check("scan_busy", 32'(bus_a.busy), 1);
    while (cyc < 200 && !got_done) begin
      if (bus_a.done) begin
        got_done = 1'b1;
      end else begin
        bus_a.mode   = 1'($urandom_range(0, 1));
        bus_a.req    = 1'($urandom_range(0, 1));
        bus_a.start  = 1'($urandom_range(0, 1));
        bus_a.select = 4'($urandom_range(0, 15));
        case (pol)
          1: bus_a.out_ready = ($urandom_range(0, 3) != 0);
          2: begin
            if (bus_a.out_valid && bus_a.out_ch == 4'd6 && stall < 3) begin
              bus_a.out_ready = 1'b0;
              stall++;
            end else begin
              bus_a.out_ready = 1'b1;
            end
          end
          default: bus_a.out_ready = 1'b1;
        endcase
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) begin
      fail_now("scan_done_timeout_cycles", cyc);
      q_a.delete();
    end else begin
      if (pol == 0) check("scan_latency", cyc, NA + 2);
      if (pol == 2) check("stall_cycles_on_ch6", stall, 3);
      check("scan_accepted", acc_a, NA);
      check("scan_queue_left", q_a.size(), 0);
      check("done_busy", 32'(bus_a.busy), 1);
      bus_a.req   = 1'b0;
      bus_a.mode  = MODE_SCAN;
      bus_a.start = 1'b1;
      @(negedge clk);
      check("done_one_cycle", 32'(bus_a.done), 0);
      check("busy_after_done", 32'(bus_a.busy), 0);
    end
    bus_a.mode  = MODE_DIRECT;
    bus_a.start = 1'b0;
  endtask

  task automatic reset_scan_a();
    exp_t e;
    drain_a();
    for (int k = 0; k < NA; k++) begin
      dat_a[k] = 8'($urandom);
      e.word   = dat_a[k];
      e.ch     = k;
      q_a.push_back(e);
    end
    load_a();
    bus_a.mode      = MODE_SCAN;
    bus_a.start     = 1'b1;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_ch", 32'(bus_a.out_ch), 4);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    q_a.delete();
    check("rst_mid_valid", 32'(bus_a.out_valid), 0);
    check("rst_mid_busy", 32'(bus_a.busy), 0);
    check("rst_mid_done", 32'(bus_a.done), 0);
    check("rst_mid_out", 32'(bus_a.out), 0);
    bus_a.mode = MODE_DIRECT;
  endtask

  initial begin : stim
    bus_a.data = '0; bus_a.mode = MODE_DIRECT; bus_a.req = 1'b0;
    bus_a.select = '0; bus_a.start = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.data = '0; bus_b.mode = MODE_DIRECT; bus_b.req = 1'b0;
    bus_b.select = '0; bus_b.start = 1'b0; bus_b.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_a", 32'(bus_a.out), 0);
    check("rst_ch_a", 32'(bus_a.out_ch), 0);
    check("rst_valid_a", 32'(bus_a.out_valid), 0);
    check("rst_busy_a", 32'(bus_a.busy), 0);
    check("rst_done_a", 32'(bus_a.done), 0);
    check("rst_valid_b", 32'(bus_b.out_valid), 0);
    check("rst_busy_b", 32'(bus_b.busy), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    dat_b = 32'hA5A5_0F0F;
    bus_b.data = dat_b;
    direct_b(4);
    for (int s = 0; s < NB; s++) direct_b(s);
    repeat (20) begin
      dat_b = $urandom;
      bus_b.data = dat_b;
      direct_b(int'($urandom_range(0, NB - 1)));
    end
    bus_b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("queue_left_b", q_b.size(), 0);

    for (int k = 0; k < NA; k++) dat_a[k] = 8'(8'h10 + k);
    load_a();
    direct_a(13);
    direct_a(4);
    dat_a[3] = 8'h07;
    dat_a[5] = 8'h03;
    load_a();
    direct_a(3);
    direct_a(5);
    scan_a(0, 1'b0);
    scan_a(2, 1'b0);
    reset_scan_a();
    scan_a(0, 1'b1);
    repeat (5) scan_a(1, 1'b1);
    scan_a(2, 1'b1);
    repeat (30) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < NA; k++) dat_a[k] = 8'($urandom);
        load_a();
      end
      direct_a(int'($urandom_range(0, 15)));
    end
    drain_a();
    check("queue_left_a", q_a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
